// File: rtl/tinycpu_trace_mon.sv
// Trace monitor for a small CPU. It queues register snapshots taken on fetch cycles
// and halts once a jump-to-self loop is seen and the queued records have drained.
module tinycpu_trace_mon #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      exec_state,
  input  logic [1:0]      instr_op,
  input  logic [DW-1:0]   rA,
  input  logic [DW-1:0]   rB,
  input  logic [DW-1:0]   rM,
  input  logic [DW-1:0]   rP,
  output logic [4*DW-1:0] trc_data,
  output logic            trc_valid,
  input  logic            trc_ready,
  output logic            loop_det,
  output logic            halted,
  output logic [15:0]     fetch_cnt,
  output logic [7:0]      drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4*DW-1:0] mem_q [DEPTH];
  logic [4*DW-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            loop_det_q, loop_det_d;
  logic [15:0]     fetch_cnt_q, fetch_cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic sample_s, pop_s, push_s, full_s, loop_hit_s;

  // Outputs come only from flops, so no CPU input reaches trc_valid/trc_data.
  assign trc_valid = (cnt_q != {(AW+1){1'b0}});
  assign trc_data  = trc_valid ? mem_q[rd_ptr_q] : {(4*DW){1'b0}};
  assign loop_det  = loop_det_q;
  assign halted    = (state_q == ST_DONE);
  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Next-state logic for the FIFO, counters and the RUN/DRAIN/DONE sequencer.
  always_comb begin
    full_s     = (cnt_q == CNT_FULL);
    pop_s      = trc_valid & trc_ready;
    sample_s   = (state_q == ST_RUN) && (exec_state == 3'd0);
    push_s     = sample_s && (!full_s || pop_s);
    // rP-1 wraps at DW bits, so rP=0 pairs with an all-ones rM.
    loop_hit_s = (exec_state == 3'd2) && (instr_op == 2'b11) && ((rP - DW'(1)) == rM);

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    loop_det_d  = loop_det_q;
    fetch_cnt_d = fetch_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = {rA, rB, rM, rP};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (sample_s) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end

    if (sample_s && !push_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    case (state_q)
      ST_RUN: begin
        if (loop_hit_s) begin
          loop_det_d = 1'b1;
          state_d    = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_d == {(AW+1){1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // State registers with asynchronous active-low reset that empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      cnt_q       <= {(AW+1){1'b0}};
      loop_det_q  <= 1'b0;
      fetch_cnt_q <= 16'd0;
      drop_cnt_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {(4*DW){1'b0}};
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      loop_det_q  <= loop_det_d;
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tinycpu_trace_mon.sv
// Scoreboard bench for tinycpu_trace_mon: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_tinycpu_trace_mon;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      exec_state;
  logic [1:0]      instr_op;
  logic [DW-1:0]   rA, rB, rM, rP;
  logic [4*DW-1:0] trc_data;
  logic            trc_valid;
  logic            trc_ready;
  logic            loop_det;
  logic            halted;
  logic [15:0]     fetch_cnt;
  logic [7:0]      drop_cnt;

  int errs   = 0;
  int checks = 0;

  // Reference model: mode 0=RUN 1=DRAIN 2=DONE.
  int          m_mode  = 0;
  bit          m_loop  = 1'b0;
  int          m_fetch = 0;
  int          m_drop  = 0;
  logic [31:0] mdl_q[$];
  logic [31:0] sb_q[$];

  tinycpu_trace_mon #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .exec_state(exec_state), .instr_op(instr_op),
    .rA(rA), .rB(rB), .rM(rM), .rP(rP), .trc_data(trc_data), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .loop_det(loop_det), .halted(halted),
    .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_loop = 1'b0; m_fetch = 0; m_drop = 0;
    mdl_q.delete(); sb_q.delete();
  endtask

  // What the spec says happens at one rising edge, given the held inputs.
  task automatic model_edge();
    bit pop, full, sample, loopc;
    pop    = (mdl_q.size() > 0) && trc_ready;
    full   = (mdl_q.size() == DEPTH);
    sample = (m_mode == 0) && (exec_state == 3'd0);
    loopc  = (m_mode == 0) && (exec_state == 3'd2) && (instr_op == 2'b11) &&
             (((int'(rP) + 255) % 256) == int'(rM));
    if (pop) void'(mdl_q.pop_front());
    if (sample) begin
      m_fetch = (m_fetch + 1) % 65536;
      if (!full || pop) begin
        mdl_q.push_back({rA, rB, rM, rP});
        sb_q.push_back({rA, rB, rM, rP});
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    case (m_mode)
      0: if (loopc) begin m_loop = 1'b1; m_mode = 1; end
      1: if (mdl_q.size() == 0) m_mode = 2;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic set_in(input logic [2:0] es, input logic [1:0] op, input logic [31:0] regs,
                        input logic rdy);
    exec_state = es; instr_op = op;
    {rA, rB, rM, rP} = regs;
    trc_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(trc_valid), 32'd0);
    chk("rst_data", trc_data, 32'd0);
    chk("rst_loop", 32'(loop_det), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch", 32'(fetch_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: status against the model every cycle, records against the scoreboard on each pop.
  always @(negedge clk) begin
    if (reset) begin
      chk("trc_valid", 32'(trc_valid), 32'(mdl_q.size() > 0));
      chk("loop_det", 32'(loop_det), 32'(m_loop));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("fetch_cnt", 32'(fetch_cnt), 32'(m_fetch));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (trc_valid && trc_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL pop_unexpected: got %h expected no record", trc_data);
        end else begin
          chk("trc_data", trc_data, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    reset = 1'b0;
    set_in(3'd1, 2'b00, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // Single fetch
    set_in(3'd0, 2'b00, 32'h01020304, 1'b1);
    tick();
    #1;
    chk("single_valid", 32'(trc_valid), 32'd1);
    chk("single_data", trc_data, 32'h01020304);
    chk("single_fetch", 32'(fetch_cnt), 32'd1);
    set_in(3'd1, 2'b00, 32'd0, 1'b1);
    tick();

    // Overflow: six samples into a four-entry queue
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_in(3'd0, 2'b00, {4{8'(i)}}, 1'b0);
      tick();
    end
    set_in(3'd1, 2'b00, 32'd0, 1'b0);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_fetch", 32'(fetch_cnt), 32'd6);
    chk("ovf_head", trc_data, 32'h01010101);
    trc_ready = 1'b1;
    repeat (4) tick();
    chk("ovf_empty", 32'(trc_valid), 32'd0);

    // Full queue with simultaneous pop and push
    for (int i = 0; i < DEPTH; i++) begin
      set_in(3'd0, 2'b00, 32'hA0B0C0D0 + 32'(i), 1'b0);
      tick();
    end
    set_in(3'd0, 2'b00, 32'h11223344, 1'b1);
    tick();
    chk("fullpop_drop", 32'(drop_cnt), 32'd2);
    chk("fullpop_fetch", 32'(fetch_cnt), 32'd11);
    set_in(3'd1, 2'b00, 32'd0, 1'b1);
    repeat (3) tick();
    chk("fullpop_last", 32'(trc_valid), 32'd1);
    tick();
    chk("fullpop_empty", 32'(trc_valid), 32'd0);

    // Loop detect with two records still queued
    do_reset();
    set_in(3'd0, 2'b00, 32'hAAAAAAAA, 1'b0); tick();
    set_in(3'd0, 2'b00, 32'hBBBBBBBB, 1'b0); tick();
    set_in(3'd2, 2'b11, 32'h33440F10, 1'b0); tick();
    chk("loop_set", 32'(loop_det), 32'd1);
    chk("loop_not_halted", 32'(halted), 32'd0);
    set_in(3'd0, 2'b00, 32'h55555555, 1'b0);
    repeat (3) tick();
    chk("drain_fetch_hold", 32'(fetch_cnt), 32'd2);
    trc_ready = 1'b1;
    tick();
    chk("drain_half", 32'(halted), 32'd0);
    tick();
    chk("drain_done", 32'(halted), 32'd1);
    repeat (2) tick();

    // Wrap-around match and near-miss
    do_reset();
    set_in(3'd2, 2'b11, 32'h0000FF00, 1'b1); tick();
    chk("wrap_match", 32'(loop_det), 32'd1);
    tick();
    chk("wrap_empty_done", 32'(halted), 32'd1);
    do_reset();
    set_in(3'd2, 2'b11, 32'h0000FE00, 1'b1); tick();
    chk("wrap_miss", 32'(loop_det), 32'd0);

    // Asynchronous reset while draining
    do_reset();
    set_in(3'd0, 2'b00, 32'h12345678, 1'b0); tick();
    set_in(3'd2, 2'b11, 32'h00002021, 1'b0); tick();
    chk("async_in_drain", 32'(loop_det), 32'd1);
    #1;
    do_reset();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rnd = $urandom();
      exec_state = (rnd[0]) ? 3'd0 : 3'($urandom_range(0, 7));
      instr_op   = 2'($urandom_range(0, 3));
      {rA, rB, rM, rP} = $urandom();
      if ($urandom_range(0, 24) == 0) begin
        exec_state = 3'd2; instr_op = 2'b11; rM = rP - 8'd1;
      end
      trc_ready = ($urandom_range(0, 2) != 0);
      tick();
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
